// File: rtl/blake2_pkg.sv
// Shared definitions for the Blake2 digest read-back path.
// Holds default bus/digest widths, derived byte counts, the reader
// state enum and a byte-count-to-word-count helper.
package blake2_pkg;

  localparam int unsigned DEF_BUS_WIDTH    = 32;
  localparam int unsigned DEF_DIGEST_WIDTH = 512;
  localparam int unsigned BUS_BYTES        = DEF_BUS_WIDTH / 8;
  localparam int unsigned DIGEST_BYTES     = DEF_DIGEST_WIDTH / 8;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } rd_state_e;

  // Number of bus words needed to carry len bytes (ceiling division).
  function automatic int unsigned bytes_to_words(input int unsigned len,
                                                 input int unsigned bus_bytes = BUS_BYTES);
    return (len + bus_bytes - 1) / bus_bytes;
  endfunction

endpackage

// File: rtl/blake2_keep_mask.sv
// Final-word byte mask generator for the digest reader.
// Ports:
//   i_nbytes    - number of valid bytes in the word (0..BUS_WIDTH/8)
//   o_keep      - one bit per byte lane, low lanes set first
//   o_zero_mask - o_keep expanded to bit granularity, used to zero dead bytes
module blake2_keep_mask
  import blake2_pkg::*;
#(
  parameter int unsigned BUS_WIDTH = DEF_BUS_WIDTH
) (
  input  logic [$clog2(BUS_WIDTH/8+1)-1:0] i_nbytes,
  output logic [BUS_WIDTH/8-1:0]           o_keep,
  output logic [BUS_WIDTH-1:0]             o_zero_mask
);

  localparam int unsigned NB    = BUS_WIDTH / 8;
  localparam int unsigned CNT_W = $clog2(NB + 1);

  for (genvar g = 0; g < NB; g++) begin : g_lane
    assign o_keep[g]            = (i_nbytes > CNT_W'(g));
    assign o_zero_mask[8*g +: 8] = {8{o_keep[g]}};
  end

endmodule

// File: rtl/blake2_digest_reader.sv
// Blake2 digest read-back: captures the engine digest on a rising
// digest_valid and streams it least-significant word first over a
// valid/ready handshake, truncated to the requested byte length.
// Optional build macro: BLAKE2_DIGEST_BSWAP_EN byte-reverses each output word
// before the keep mask is applied.
// Ports:
//   i_clk, i_reset_n       - clock, async active-low reset
//   i_digest, i_digest_valid, i_out_len - engine digest, done level, byte length
//   i_new_hash_request     - abort any readout, clear overrun
//   o_dout, o_dout_valid, i_dout_ready, o_dout_last, o_dout_keep - word stream
//   o_busy                 - digest held and not fully read
//   o_overrun              - sticky: digest arrived while busy
module blake2_digest_reader
  import blake2_pkg::*;
#(
  parameter int unsigned BUS_WIDTH    = DEF_BUS_WIDTH,
  parameter int unsigned DIGEST_WIDTH = DEF_DIGEST_WIDTH,
  parameter int unsigned OUT_LEN_W    = $clog2(DIGEST_WIDTH / 8) + 1
) (
  input  logic                    i_clk,
  input  logic                    i_reset_n,
  input  logic [DIGEST_WIDTH-1:0] i_digest,
  input  logic                    i_digest_valid,
  input  logic [OUT_LEN_W-1:0]    i_out_len,
  input  logic                    i_new_hash_request,
  output logic [BUS_WIDTH-1:0]    o_dout,
  output logic                    o_dout_valid,
  input  logic                    i_dout_ready,
  output logic                    o_dout_last,
  output logic [BUS_WIDTH/8-1:0]  o_dout_keep,
  output logic                    o_busy,
  output logic                    o_overrun
);

  localparam int unsigned W_BYTES = BUS_WIDTH / 8;
  localparam int unsigned D_BYTES = DIGEST_WIDTH / 8;
  localparam int unsigned N_WORDS = DIGEST_WIDTH / BUS_WIDTH;
  localparam int unsigned PTR_W   = $clog2(N_WORDS + 1);
  localparam int unsigned IDX_W   = (N_WORDS > 1) ? $clog2(N_WORDS) : 1;
  localparam int unsigned CNT_W   = $clog2(W_BYTES + 1);

  rd_state_e                r_state, w_state_d;
  logic                     r_dv;
  logic [DIGEST_WIDTH-1:0]  r_digest, w_digest_d;
  logic [PTR_W-1:0]         r_ptr, w_ptr_d;
  logic [PTR_W-1:0]         r_nwords, w_nwords_d;
  logic [CNT_W-1:0]         r_last_bytes, w_last_bytes_d;
  logic                     r_overrun, w_overrun_d;

  logic                     w_rise;
  logic                     w_is_last;
  logic [OUT_LEN_W-1:0]     w_len;
  logic [PTR_W-1:0]         w_len_words;
  logic [CNT_W-1:0]         w_last_cnt;
  int unsigned              w_len_rem;

  assign w_rise    = i_digest_valid & ~r_dv;
  assign w_is_last = (r_ptr == r_nwords - PTR_W'(1));

  // Zero or oversized requests mean the full digest.
  always_comb begin
    w_len = i_out_len;
    if (i_out_len == '0 || 32'(i_out_len) > D_BYTES) begin
      w_len = OUT_LEN_W'(D_BYTES);
    end
    w_len_words = PTR_W'(bytes_to_words(32'(w_len), W_BYTES));
    w_len_rem   = 32'(w_len) % W_BYTES;
    w_last_cnt  = (w_len_rem == 0) ? CNT_W'(W_BYTES) : CNT_W'(w_len_rem);
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state      <= IDLE;
      r_dv         <= 1'b0;
      r_digest     <= '0;
      r_ptr        <= '0;
      r_nwords     <= '0;
      r_last_bytes <= '0;
      r_overrun    <= 1'b0;
    end else begin
      r_state      <= w_state_d;
      r_dv         <= i_digest_valid;
      r_digest     <= w_digest_d;
      r_ptr        <= w_ptr_d;
      r_nwords     <= w_nwords_d;
      r_last_bytes <= w_last_bytes_d;
      r_overrun    <= w_overrun_d;
    end
  end

  always_comb begin
    w_state_d      = r_state;
    w_digest_d     = r_digest;
    w_ptr_d        = r_ptr;
    w_nwords_d     = r_nwords;
    w_last_bytes_d = r_last_bytes;
    w_overrun_d    = r_overrun;
    // Abort outranks both capture and transfer.
    if (i_new_hash_request) begin
      w_state_d   = IDLE;
      w_overrun_d = 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_rise) begin
            w_digest_d     = i_digest;
            w_ptr_d        = '0;
            w_nwords_d     = w_len_words;
            w_last_bytes_d = w_last_cnt;
            w_state_d      = SEND;
          end
        end
        SEND: begin
          // A new digest while streaming is dropped; the old one keeps going.
          if (w_rise) begin
            w_overrun_d = 1'b1;
          end
          if (i_dout_ready) begin
            if (w_is_last) begin
              w_state_d = IDLE;
            end else begin
              w_ptr_d = r_ptr + PTR_W'(1);
            end
          end
        end
        default: w_state_d = IDLE;
      endcase
    end
  end

  // Output word selection and masking.
  logic [N_WORDS-1:0][BUS_WIDTH-1:0] w_words;
  logic [BUS_WIDTH-1:0]              w_word_raw;
  logic [BUS_WIDTH-1:0]              w_word;
  logic [CNT_W-1:0]                  w_keep_cnt;
  logic [W_BYTES-1:0]                w_keep;
  logic [BUS_WIDTH-1:0]              w_zero_mask;

  assign w_words    = r_digest;
  assign w_word_raw = w_words[r_ptr[IDX_W-1:0]];
  assign w_keep_cnt = w_is_last ? r_last_bytes : CNT_W'(W_BYTES);

`ifdef BLAKE2_DIGEST_BSWAP_EN
  always_comb begin
    w_word = '0;
    for (int b = 0; b < W_BYTES; b++) begin
      w_word[8*b +: 8] = w_word_raw[8*(W_BYTES-1-b) +: 8];
    end
  end
`else
  assign w_word = w_word_raw;
`endif

  blake2_keep_mask #(
    .BUS_WIDTH (BUS_WIDTH)
  ) u_keep_mask (
    .i_nbytes    (w_keep_cnt),
    .o_keep      (w_keep),
    .o_zero_mask (w_zero_mask)
  );

  always_comb begin
    o_dout       = '0;
    o_dout_valid = 1'b0;
    o_dout_last  = 1'b0;
    o_dout_keep  = '0;
    if (r_state == SEND) begin
      o_dout       = w_word & w_zero_mask;
      o_dout_valid = 1'b1;
      o_dout_last  = w_is_last;
      o_dout_keep  = w_keep;
    end
  end

  assign o_busy    = (r_state == SEND);
  assign o_overrun = r_overrun;

endmodule

// File: doc/blake2_digest_reader.md
# blake2_digest_reader

Read-back side of the Blake2 hash path. Captures the digest presented by the hash engine when `digest_valid` rises, then streams it to the processor as BUS_WIDTH-bit words over a valid/ready handshake, least-significant word first. Honours a requested output length (Blake2 variable digest size) with a byte-keep mask on the final word. Flags digests lost while a previous one is still being read out.

## Interface
- BUS_WIDTH, 32: processor data word width; multiple of 8.
- DIGEST_WIDTH, 512: engine digest width; multiple of BUS_WIDTH.
- OUT_LEN_W, $clog2(DIGEST_WIDTH/8)+1: width of `out_len`; 7 at defaults.

- clk  in  1  single clock; all logic on posedge.
- reset_n  in  1  reset, asynchronous, active-low.
- digest  in  DIGEST_WIDTH  engine digest; sampled only on the capture cycle.
- digest_valid  in  1  engine done; level, may stay high for many cycles.
- out_len  in  OUT_LEN_W  requested digest bytes; sampled on the capture cycle.
- new_hash_request  in  1  processor starts a new hash; aborts any readout.
- dout  out  BUS_WIDTH  digest word; unused bytes of the final word read 0.
- dout_valid  out  1  `dout` holds a word.
- dout_ready  in  1  processor accepts the word.
- dout_last  out  1  current word is the final one.
- dout_keep  out  BUS_WIDTH/8  valid-byte mask; bit i covers dout[8i+7:8i].
- busy  out  1  digest held and not fully read.
- overrun  out  1  sticky: a digest arrived while busy.

## Operation
- FSM states: IDLE, SEND.
- Rising-edge detect on `digest_valid` using a registered copy (reset 0). A held level triggers one capture only.
- IDLE, rise seen, `new_hash_request`=0: latch `digest`, compute word count = ceil(len/BUS_BYTES) and last-word byte count, set word pointer to 0, go to SEND.
- Effective len: `out_len`=0 or `out_len` > DIGEST_WIDTH/8 means DIGEST_WIDTH/8 bytes.
- SEND: `dout` = captured[ptr*BUS_WIDTH +: BUS_WIDTH]; `dout_valid`=1. On `dout_valid && dout_ready`, advance ptr. Transfer of the last word returns to IDLE.
- `dout_keep` is all ones except on the last word, where the low (len mod BUS_BYTES) bits are set; if that remainder is 0, all ones. Bytes with keep=0 are driven 0.
- Rise seen in SEND: set `overrun`, discard the new digest, and keep streaming the old one.
- `new_hash_request` in any state: go to IDLE, drop `dout_valid`, clear `overrun`, and suppress a capture in the same cycle. Abort has priority over both capture and transfer.
- `busy` = (state == SEND).

## Timing
- Reset values: `dout`=0, `dout_valid`=0, `dout_last`=0, `dout_keep`=0, `busy`=0, `overrun`=0, state IDLE.
- Latency: rising `digest_valid` sampled at edge k makes word 0 valid after edge k (registered outputs); `busy` rises at the same edge.
- `dout`, `dout_keep` and `dout_last` are stable while `dout_valid && !dout_ready`.
- Back-to-back transfers at 1 word/cycle when `dout_ready` is held high.
- After the last transfer at edge m, the block is in IDLE from edge m. A rise sampled at edge m+1 is captured without overrun.
- A rise at the same edge as the last transfer counts as arriving while busy: it sets `overrun` and is not captured.
- Reset mid-readout: all outputs return to reset values immediately (asynchronous).

## Configuration
- `BLAKE2_DIGEST_BSWAP_EN`:
  - Defined: each output word is byte-reversed before the keep mask is applied. Keep bits still index the output byte lanes (lane 0 = dout[7:0]).
  - Undefined: bytes pass through in engine order.
  - Pointer, count and handshake behaviour are identical in both builds.

## Structure
- Shared package `blake2_pkg`:
  - BUS_WIDTH and DIGEST_WIDTH defaults.
  - BUS_BYTES and DIGEST_BYTES constants.
  - Reader state enum {IDLE, SEND}.
  - Function `bytes_to_words(len)`.
- One sub-module, `blake2_keep_mask`: combinational; maps a byte count (0..BUS_BYTES) to the keep mask and the zeroing mask. Used for the final word.

## Test plan
- Full digest: `out_len`=0, `digest`=512'h…0F0E…0100 (byte i = i), `dout_ready`=1. Expect 16 words on consecutive cycles: first word 32'h03020100, `dout_last` only on word 15, keep 4'hF throughout, then `busy`=0.
- Truncated: `out_len`=30. Expect 8 words; word 7 = 32'h00001D1C with keep 4'b0011 and `dout_last`=1.
- Backpressure: toggle `dout_ready` 1,0,0,1 during word 2. `dout` is held unchanged for 3 cycles and no word is skipped or duplicated.
- Overrun: second `digest_valid` rise while on word 5. Expect `overrun`=1 and the first digest completes unchanged. A following `new_hash_request` clears `overrun`.
- Abort: `new_hash_request` on word 3, `digest_valid` held high. Expect `dout_valid`=0 next cycle, IDLE, and no recapture from the held level.
- Reset: assert `reset_n`=0 mid-readout, asynchronous to clk. All outputs are 0 immediately; after release, a fresh rise streams normally.
